// File: rtl/snow64_normalize_unit.sv
// Iterative 64-bit normalizer: scans one 16-bit chunk per cycle from the MSB end,
// accumulating the leading-zero count, then registers the left-shifted operand.
module snow64_normalize_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [6:0]  out_lzc,
  output logic        out_zero
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state_r, state_nxt;
  logic [63:0] data_r;
  logic [6:0]  cnt_r;
  logic [1:0]  idx_r;
  logic [15:0] chunk;
  logic [4:0]  chunk_clz;
  logic        chunk_zero;
  logic [6:0]  cnt_final;

  function automatic logic [4:0] clz16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd16;
    // Ascending scan: the last hit is the highest set bit.
    for (int i = 0; i < 16; i++) begin
      if (v[i]) n = 5'(15 - i);
    end
    return n;
  endfunction

  always_comb begin
    chunk = data_r[63:48];
    case (idx_r)
      2'd0:    chunk = data_r[63:48];
      2'd1:    chunk = data_r[47:32];
      2'd2:    chunk = data_r[31:16];
      default: chunk = data_r[15:0];
    endcase
  end

  // Single shared clz16 across all scan cycles.
  assign chunk_clz  = clz16(chunk);
  assign chunk_zero = (chunk == 16'd0);
  assign cnt_final  = cnt_r + {2'b00, chunk_clz};

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    if (in_valid) state_nxt = SCAN;
      SCAN:    if (!chunk_zero || idx_r == 2'd3) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r   <= 64'd0;
      cnt_r    <= 7'd0;
      idx_r    <= 2'd0;
      out_data <= 64'd0;
      out_lzc  <= 7'd0;
      out_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_r <= in_data;
            cnt_r  <= 7'd0;
            idx_r  <= 2'd0;
          end
        end
        SCAN: begin
          if (!chunk_zero) begin
            cnt_r    <= cnt_final;
            out_data <= data_r << cnt_final;
            out_lzc  <= cnt_final;
            out_zero <= 1'b0;
          end else if (idx_r == 2'd3) begin
            cnt_r    <= 7'd64;
            out_data <= 64'd0;
            out_lzc  <= 7'd64;
            out_zero <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 7'd16;
            idx_r <= idx_r + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_normalize_unit.sv
// Directed and randomized checks of snow64_normalize_unit against hand-computed
// values and a bit-serial CLZ reference.
module tb_snow64_normalize_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [6:0]  out_lzc;
  logic        out_zero;

  int n_vec;
  int n_err;

  snow64_normalize_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_lzc  (out_lzc),
    .out_zero (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ref_lzc(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) break;
      n++;
    end
    return n;
  endfunction

  // edges_exp counts the acceptance edge itself as the first edge.
  task automatic run_op(input string tag, input logic [63:0] d, input int lzc_exp,
                        input logic [63:0] data_exp, input int edges_exp, input int hold);
    int waitc;
    int edges;
    logic [63:0] held_data;
    logic [6:0]  held_lzc;
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk({tag, " in_ready_before"}, 64'(in_ready), 64'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_data   = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, " latency"}, 64'(edges), 64'(edges_exp));
    chk({tag, " lzc"}, 64'(out_lzc), 64'(lzc_exp));
    chk({tag, " data"}, out_data, data_exp);
    chk({tag, " zero"}, 64'(out_zero), 64'(lzc_exp == 64));
    if (lzc_exp != 64) chk({tag, " msb"}, 64'(out_data[63]), 64'd1);
    chk({tag, " in_ready_done"}, 64'(in_ready), 64'd0);
    held_data = out_data;
    held_lzc  = out_lzc;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, " hold_data"}, out_data, held_data);
      chk({tag, " hold_lzc"}, 64'(out_lzc), 64'(held_lzc));
      chk({tag, " hold_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " idle_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " idle_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] raw;
    logic [63:0] d;
    logic [63:0] dexp;
    int sh;
    int lz;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 64'd0;
    out_ready = 1'b0;
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data", out_data, 64'd0);
    chk("rst out_lzc", 64'(out_lzc), 64'd0);
    chk("rst out_zero", 64'(out_zero), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst in_ready", 64'(in_ready), 64'd1);

    run_op("msb",   64'h8000_0000_0000_0000, 0,  64'h8000_0000_0000_0000, 2, 0);
    run_op("bit16", 64'h0000_0000_0001_0000, 47, 64'h8000_0000_0000_0000, 4, 0);
    run_op("zero",  64'h0000_0000_0000_0000, 64, 64'h0000_0000_0000_0000, 5, 0);
    run_op("lsb",   64'h0000_0000_0000_0001, 63, 64'h8000_0000_0000_0000, 5, 3);
    run_op("chunk1",64'h0000_8000_0000_0000, 16, 64'h8000_0000_0000_0000, 3, 1);
    run_op("mixed", 64'h0123_4567_89AB_CDEF, 7,  64'h91A2_B3C4_D5E6_F780, 2, 0);

    // Abort a scan with reset, then confirm the block is clean.
    in_valid = 1'b1;
    in_data  = 64'h0000_0000_0000_00FF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort in_ready", 64'(in_ready), 64'd1);
    chk("abort out_lzc", 64'(out_lzc), 64'd0);
    chk("abort out_data", out_data, 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("abort no_result", 64'(out_valid), 64'd0);
    end
    run_op("after_rst", 64'h00F0_0000_0000_0000, 8, 64'hF000_0000_0000_0000, 2, 0);

    for (int t = 0; t < 40; t++) begin
      raw = {$urandom, $urandom};
      sh  = $urandom_range(0, 64);
      d   = (sh == 64) ? 64'd0 : (raw >> sh);
      lz  = ref_lzc(d);
      dexp = (lz == 64) ? 64'd0 : (d << lz);
      run_op($sformatf("rnd%0d", t), d, lz, dexp, (lz == 64) ? 5 : (lz / 16) + 2,
             $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/snow64_normalize_unit.md
SNOW64_NORMALIZE_UNIT -- requirements
Module: snow64_normalize_unit

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 Clocking: one clock `clk`; reset `rst_n` is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream presents in_data.
REQ-006 in_ready  output  1  block can accept an operand (combinational from state).
REQ-007 in_data  input  64  operand to normalize.
REQ-008 out_valid  output  1  result registers hold a valid result.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_data  output  64  operand shifted left by out_lzc; zero when operand is zero.
REQ-011 out_lzc  output  7  leading-zero count of the operand, range 0..64.
REQ-012 out_zero  output  1  operand was all zeros.

Function
REQ-013 FSM states: IDLE, SCAN, DONE; the block has no other states.
REQ-014 IDLE: in_ready=1, out_valid=0.
REQ-015 IDLE: in_valid=1 captures in_data into data_r, clears cnt_r (7b) and idx_r (2b), and goes to SCAN.
REQ-016 SCAN: in_ready=0, out_valid=0.
REQ-017 SCAN: each cycle examines one 16-bit chunk, data_r[63-16*idx_r -: 16], starting at the MSB chunk.
REQ-018 SCAN, chunk nonzero: cnt_r += clz16(chunk) (0..15); go to DONE.
REQ-019 SCAN, chunk zero, idx_r<3: cnt_r += 16; idx_r += 1; stay in SCAN.
REQ-020 SCAN, chunk zero, idx_r==3: cnt_r becomes 64; out_zero is set; go to DONE.
REQ-021 clz16 is the standard 16-bit count-leading-zeros with a 5-bit result (16 for zero input).
REQ-022 clz16 is instantiated once and reused across scan cycles.
REQ-023 On the SCAN->DONE transition, out_data, out_lzc and out_zero are registered.
REQ-024 out_data = data_r << final count, truncated to 64 bits; a count of 64 yields 0.
REQ-025 In a normalized result, out_data[63]=1 whenever out_zero=0.
REQ-026 DONE: out_valid=1, in_ready=0.
REQ-027 DONE: out_data, out_lzc and out_zero stay stable while out_ready=0.
REQ-028 DONE with out_ready=1: go to IDLE.
REQ-029 A new operand is not accepted on the DONE->IDLE transition edge; the earliest next acceptance is the following cycle.
REQ-030 Latency: with k = index of the first nonzero chunk + 1, or 4 if all chunks are zero, out_valid rises k+1 clock edges after the acceptance edge.
REQ-031 Throughput is at most one operand per k+2 cycles.
REQ-032 in_valid and in_data are ignored outside IDLE; upstream holds its values under the valid/ready rule.
REQ-033 out_ready is ignored outside DONE.
REQ-034 cnt_r never exceeds 64; no arithmetic overflow is possible.
REQ-035 Operations cannot be aborted; only reset terminates an operation.

Reset
REQ-036 rst_n=0 asynchronously forces: state=IDLE, out_valid=0, out_data=0, out_lzc=0, out_zero=0, cnt_r=0, idx_r=0, data_r=0.
REQ-037 in_ready=1 while in reset and immediately after reset.
REQ-038 Reset asserted in SCAN or DONE discards the operation; no result is emitted after reset.
REQ-039 Release of rst_n is synchronous to clk; the first acceptance can occur on the first rising edge after release.

Verification
REQ-040 in_data=0x8000_0000_0000_0000, out_ready=1 -> out_valid after 2 edges; out_lzc=0, out_data unchanged, out_zero=0.
REQ-041 in_data=0x0000_0000_0001_0000 -> out_valid after 4 edges; out_lzc=47, out_data=0x8000_0000_0000_0000.
REQ-042 in_data=0 -> out_valid after 5 edges; out_lzc=64, out_data=0, out_zero=1.
REQ-043 in_data=0x0000_0000_0000_0001 with out_ready=0 for 3 cycles -> out_lzc=63 and out_data=0x8000_0000_0000_0000 held stable; in_ready=0 throughout; IDLE after out_ready=1.
REQ-044 Reset pulse during SCAN of in_data=0x0000_0000_0000_00FF -> out_valid=0, in_ready=1 after reset; the next operand 0x00F0_0000_0000_0000 gives out_lzc=8.
REQ-045 Random back-to-back operands with random out_ready -> every result matches a reference CLZ/shift model; no result is lost or duplicated; out_data[63]=1 for every nonzero operand.
